// File: rtl/seq_gen_1011.sv
// Serial pattern generator: sends PATTERN (MSB first) reps times per frame,
// with gap zero bits between repetitions and a one-cycle done pulse at the end.
//
// state | meaning
// IDLE  | waiting for start with nonzero reps
// SEND  | shifting out the four pattern bits
// GAP   | emitting zero bits between repetitions
// DONE  | one-cycle end-of-frame pulse
module seq_gen_1011 #(
   parameter logic [3:0] PATTERN = 4'b1011
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] reps,
   input  logic [1:0] gap,
   input  logic       abort,
   output logic       out,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] bit_idx, bit_nxt;
   logic [3:0] rep_cnt, rep_nxt;
   logic [3:0] rep_dec;
   logic [1:0] gap_lat, gap_lat_nxt;
   logic [1:0] gap_cnt, gap_cnt_nxt;
   logic       out_nxt, valid_nxt, busy_nxt, done_nxt;

   // Next-state, counter and output decode; outputs follow the next state so
   // they land in registers aligned with the state they describe.
   always_comb begin
      state_nxt   = state;
      bit_nxt     = bit_idx;
      rep_nxt     = rep_cnt;
      gap_lat_nxt = gap_lat;
      gap_cnt_nxt = gap_cnt;
      rep_dec     = rep_cnt - 4'd1;

      case (state)
         IDLE: begin
            if (start && (reps != 4'd0)) begin
               state_nxt   = SEND;
               bit_nxt     = 2'd3;
               rep_nxt     = reps;
               gap_lat_nxt = gap;
               gap_cnt_nxt = 2'd0;
            end
         end
         SEND: begin
            if (abort) begin
               state_nxt   = IDLE;
               bit_nxt     = 2'd0;
               rep_nxt     = 4'd0;
               gap_lat_nxt = 2'd0;
               gap_cnt_nxt = 2'd0;
            end else if (bit_idx != 2'd0) begin
               bit_nxt = bit_idx - 2'd1;
            end else begin
               rep_nxt = rep_dec;
               if (rep_dec == 4'd0) begin
                  state_nxt = DONE;
               end else if (gap_lat == 2'd0) begin
                  state_nxt = SEND;
                  bit_nxt   = 2'd3;
               end else begin
                  state_nxt   = GAP;
                  gap_cnt_nxt = gap_lat;
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt   = IDLE;
               bit_nxt     = 2'd0;
               rep_nxt     = 4'd0;
               gap_lat_nxt = 2'd0;
               gap_cnt_nxt = 2'd0;
            end else if (gap_cnt == 2'd1) begin
               state_nxt   = SEND;
               bit_nxt     = 2'd3;
               gap_cnt_nxt = 2'd0;
            end else begin
               gap_cnt_nxt = gap_cnt - 2'd1;
            end
         end
         DONE: begin
            state_nxt   = IDLE;
            bit_nxt     = 2'd0;
            rep_nxt     = 4'd0;
            gap_lat_nxt = 2'd0;
            gap_cnt_nxt = 2'd0;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      out_nxt   = (state_nxt == SEND) ? PATTERN[bit_nxt] : 1'b0;
      valid_nxt = (state_nxt == SEND) || (state_nxt == GAP);
      busy_nxt  = valid_nxt;
      done_nxt  = (state_nxt == DONE);
   end

   // State, counters and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_idx   <= 2'd0;
         rep_cnt   <= 4'd0;
         gap_lat   <= 2'd0;
         gap_cnt   <= 2'd0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_idx   <= bit_nxt;
         rep_cnt   <= rep_nxt;
         gap_lat   <= gap_lat_nxt;
         gap_cnt   <= gap_cnt_nxt;
         out       <= out_nxt;
         out_valid <= valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: doc/seq_gen_1011.md
SEQ_GEN_1011 -- requirements
Module: seq_gen_1011

Interface
REQ-001 The block SHALL have parameter PATTERN, default 4'b1011, meaning the 4-bit pattern transmitted MSB first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a frame; sampled only in IDLE.
REQ-005 The block SHALL have port reps, input, 4 bits: number of pattern repetitions per frame, 1-15; sampled with start.
REQ-006 The block SHALL have port gap, input, 2 bits: number of idle zero bits between repetitions, 0-3; sampled with start.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-008 The block SHALL have port out, output, 1 bit: registered serial data bit.
REQ-009 The block SHALL have port out_valid, output, 1 bit: registered; high while out carries a frame bit (pattern or gap).
REQ-010 The block SHALL have port busy, output, 1 bit: registered; high from the first frame bit through the last frame bit.
REQ-011 The block SHALL have port done, output, 1 bit: registered; one-cycle pulse after the last frame bit.

Function
REQ-012 The block SHALL implement four states: IDLE, SEND, GAP and DONE.
REQ-013 In IDLE, with start=1 and reps!=0, the block SHALL latch reps and gap and enter SEND at the next edge.
REQ-014 The first pattern bit SHALL appear on out in the cycle after start is sampled (latency 1).
REQ-015 In IDLE, start=1 with reps=0 SHALL be ignored: the block stays in IDLE, with no done pulse and no out_valid.
REQ-016 SEND SHALL last exactly 4 cycles and drive out = PATTERN[3], [2], [1], [0] in order, with out_valid=1 and busy=1.
REQ-017 After the 4th bit, the remaining-repetition count SHALL decrement by 1.
REQ-018 After the decrement, if the remaining count is 0, the block SHALL enter DONE.
REQ-019 After the decrement, if the remaining count is not 0 and the latched gap is 0, the block SHALL enter SEND with no bubble.
REQ-020 After the decrement, if the remaining count is not 0 and the latched gap is not 0, the block SHALL enter GAP.
REQ-021 GAP SHALL last exactly the latched gap number of cycles, driving out=0, out_valid=1 and busy=1, and SHALL then return to SEND.
REQ-022 No gap SHALL follow the final repetition.
REQ-023 DONE SHALL last one cycle, driving done=1, busy=0, out_valid=0 and out=0, and SHALL then enter IDLE.
REQ-024 A frame SHALL contain reps*4 + (reps-1)*gap valid cycles; done SHALL assert in the cycle after the last valid bit.
REQ-025 start SHALL be ignored in SEND, GAP and DONE.
REQ-026 Changes on reps and gap during a frame SHALL have no effect on that frame.
REQ-027 The earliest accepted next start SHALL be the cycle after DONE, i.e. while in IDLE.
REQ-028 abort=1 in SEND or GAP SHALL enter IDLE at the next edge, clearing out, out_valid and busy, with no done pulse.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 If abort and start are both 1 in IDLE, start SHALL take effect.
REQ-031 Outside SEND and GAP, out SHALL be 0 and out_valid SHALL be 0.
REQ-032 Internal counters SHALL be sized so that no wrap-around occurs: 2-bit bit index, 4-bit repetition count, 2-bit gap count.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE and out=0, out_valid=0, busy=0, done=0, and clear all counters, regardless of state.
REQ-034 rst SHALL have priority over start and abort.
REQ-035 After rst is released, the block SHALL accept start in the first cycle.
REQ-036 rst mid-frame SHALL produce no done pulse.

Verification
REQ-037 Reset scenario: rst=1 for 2 cycles from unknown state -> out=0, out_valid=0, busy=0, done=0 on the first edge.
REQ-038 Single-frame scenario: start, reps=1, gap=0 -> out=1,0,1,1 with out_valid=1 in cycles 1-4 after start; done=1 in cycle 5 only.
REQ-039 Gapped-frame scenario: start, reps=3, gap=2 -> out=1011 00 1011 00 1011 (16 valid cycles); done in cycle 17; busy high in cycles 1-16.
REQ-040 Ignore scenario: start with reps=0 -> no activity. Also: start pulsed in cycle 2 of a reps=2 frame -> frame unchanged, exactly one done.
REQ-041 Abort/reset scenario: abort in the 1st GAP cycle of reps=2, gap=3 -> IDLE next edge, no done. rst in cycle 2 of a frame -> all outputs 0 next edge; a new start then produces a full correct frame.
REQ-042 Loopback scenario: out drives the team's non-overlapping 1011 Mealy detector input, with reps=2, gap=0 (10111011) and with reps=2, gap=1 (101101011) -> detector output pulses exactly twice in each case.
